// File: rtl/light_conflict_monitor.sv
// Safety monitor for the intersection light buses.
// Decodes, debounces and checks both directions; latches the first fault.
module light_conflict_monitor #(
    parameter int          SETTLE     = 4,
    parameter logic [31:0] MIN_YELLOW = 32'd100_000_000,
    parameter logic [31:0] MAX_GREEN  = 32'd800_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ns_light,
    input  logic [7:0] ew_light,
    input  logic       clear_fault,
    output logic [2:0] ns_color,
    output logic [2:0] ew_color,
    output logic       valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_ew
);

    localparam int RW = $clog2(SETTLE + 1);
    localparam logic [RW-1:0] RMAX = RW'(SETTLE);
    localparam logic [RW-1:0] RONE = RW'(1);

    localparam logic [2:0] C_OFF = 3'd0;
    localparam logic [2:0] C_RED = 3'd1;
    localparam logic [2:0] C_YEL = 3'd2;
    localparam logic [2:0] C_GRN = 3'd3;
    localparam logic [2:0] C_ERR = 3'd4;
    localparam logic [2:0] C_INV = 3'd7;

    function automatic logic [2:0] decode(input logic [7:0] c);
        unique case (c)
            8'b10001000: decode = C_RED;
            8'b10011001: decode = C_YEL;
            8'b10000010: decode = C_GRN;
            8'b10000000: decode = C_ERR;
            8'b11111111: decode = C_OFF;
            default:     decode = C_INV;
        endcase
    endfunction

    function automatic logic conflict(input logic [2:0] a, input logic [2:0] b);
        conflict = (a == C_GRN && (b == C_GRN || b == C_YEL))
                || (b == C_GRN && a == C_YEL);
    endfunction

    // Index 0 is north/south, index 1 is east/west.
    logic [7:0]    raw     [2];
    logic [7:0]    prev_q  [2];
    logic [RW-1:0] run_q   [2];
    logic [RW-1:0] run_n   [2];
    logic [2:0]    cls_q   [2];
    logic [2:0]    cls_n   [2];
    logic          seen_q  [2];
    logic          seen_n  [2];
    logic [31:0]   dwell_q [2];
    logic [31:0]   dwell_n [2];
    logic [1:0]    inv_n, inv_new, seq_f, shy_f, lng_f;
    logic          valid_q, valid_n;
    logic          cf_n, cf_c;
    logic          fault_q, few_q;
    logic [2:0]    code_q;
    logic [8:0]    vfull, vnew, src;
    logic          hit, hit_ew;
    logic [2:0]    hit_code;

    // Settle filter, dwell counters and per-channel transition checks.
    always_comb begin
        raw[0] = ns_light;
        raw[1] = ew_light;
        for (int i = 0; i < 2; i++) begin
            if (raw[i] == prev_q[i])
                run_n[i] = (run_q[i] == RMAX) ? run_q[i] : run_q[i] + RONE;
            else
                run_n[i] = RONE;
            cls_n[i]  = (run_n[i] == RMAX) ? decode(raw[i]) : cls_q[i];
            seen_n[i] = seen_q[i] | (run_n[i] == RMAX);
            if (cls_n[i] != cls_q[i])
                dwell_n[i] = 32'd1;
            else if (dwell_q[i] == 32'hFFFF_FFFF)
                dwell_n[i] = dwell_q[i];
            else
                dwell_n[i] = dwell_q[i] + 32'd1;
            inv_n[i]   = cls_n[i] == C_INV;
            inv_new[i] = inv_n[i] && !(valid_q && cls_q[i] == C_INV);
            seq_f[i]   = cls_q[i] == C_GRN && cls_n[i] == C_RED;
            shy_f[i]   = cls_q[i] == C_YEL && cls_n[i] == C_RED
                      && dwell_q[i] < MIN_YELLOW;
            lng_f[i]   = cls_n[i] == C_GRN
                      && {1'b0, dwell_n[i]} == {1'b0, MAX_GREEN} + 33'd1;
        end
    end

    // Gather violations; pick the highest-priority one.
    always_comb begin
        valid_n = seen_n[0] & seen_n[1];
        cf_n    = valid_n && conflict(cls_n[0], cls_n[1]);
        cf_c    = valid_q && conflict(cls_q[0], cls_q[1]);
        vfull   = {lng_f[1], lng_f[0], shy_f[1], shy_f[0],
                   seq_f[1], seq_f[0], inv_n[1], inv_n[0], cf_n};
        vnew    = {lng_f[1], lng_f[0], shy_f[1], shy_f[0],
                   seq_f[1], seq_f[0], inv_new[1], inv_new[0], cf_n && !cf_c};
        if (!valid_n) begin
            vfull = '0;
            vnew  = '0;
        end
        src      = fault_q ? vnew : vfull;
        hit      = 1'b0;
        hit_code = 3'd0;
        hit_ew   = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            if (src[k]) begin
                hit = 1'b1;
                if (k == 0) begin
                    hit_code = 3'd1;
                    hit_ew   = 1'b0;
                end else begin
                    hit_code = 3'((k - 1) / 2 + 2);
                    hit_ew   = ((k - 1) % 2) == 1;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i]  <= '0;
                run_q[i]   <= '0;
                cls_q[i]   <= C_OFF;
                seen_q[i]  <= 1'b0;
                dwell_q[i] <= '0;
            end
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i]  <= raw[i];
                run_q[i]   <= run_n[i];
                cls_q[i]   <= cls_n[i];
                seen_q[i]  <= seen_n[i];
                dwell_q[i] <= dwell_n[i];
            end
            valid_q <= valid_n;
        end
    end

    // Sticky fault latch; a fresh violation beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            few_q   <= 1'b0;
        end else if (hit && (!fault_q || clear_fault)) begin
            fault_q <= 1'b1;
            code_q  <= hit_code;
            few_q   <= hit_ew;
        end else if (clear_fault) begin
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            few_q   <= 1'b0;
        end
    end

    assign ns_color   = cls_q[0];
    assign ew_color   = cls_q[1];
    assign valid      = valid_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_ew   = few_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor with small timing parameters.
// Expected outputs are queued with stimulus and compared after each edge.
module tb_light_conflict_monitor;

    localparam logic [7:0] R = 8'b10001000;
    localparam logic [7:0] Y = 8'b10011001;
    localparam logic [7:0] G = 8'b10000010;
    localparam logic [7:0] X = 8'h55;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       v;
        logic       f;
        logic [2:0] c;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ns_light = R;
    logic [7:0] ew_light = R;
    logic       clear_fault = 1'b0;
    logic [2:0] ns_color, ew_color, fault_code;
    logic       valid, fault, fault_ew;

    int n_chk = 0;
    int n_err = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    light_conflict_monitor #(
        .SETTLE(2), .MIN_YELLOW(32'd8), .MAX_GREEN(32'd20)
    ) dut (
        .clk(clk), .reset(reset),
        .ns_light(ns_light), .ew_light(ew_light),
        .clear_fault(clear_fault),
        .ns_color(ns_color), .ew_color(ew_color),
        .valid(valid), .fault(fault),
        .fault_code(fault_code), .fault_ew(fault_ew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".ns"}, int'(ns_color), int'(e.ns));
        check({t, ".ew"}, int'(ew_color), int'(e.ew));
        check({t, ".valid"}, int'(valid), int'(e.v));
        check({t, ".fault"}, int'(fault), int'(e.f));
        check({t, ".code"}, int'(fault_code), int'(e.c));
        check({t, ".dir"}, int'(fault_ew), int'(e.fe));
    endtask

    task automatic drive(input logic [7:0] n, input logic [7:0] e,
                         input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset = 1'b0; clear_fault = 1'b0;
            ns_light = n; ew_light = e;
            @(posedge clk);
        end
    endtask

    task automatic dc(input logic [7:0] n, input logic [7:0] e,
                      input logic clr,
                      input logic [2:0] xns, input logic [2:0] xew,
                      input logic xv, input logic xf,
                      input logic [2:0] xc, input logic xfe,
                      input string tag);
        @(negedge clk);
        reset = 1'b0; clear_fault = clr;
        ns_light = n; ew_light = e;
        exp_q.push_back('{xns, xew, xv, xf, xc, xfe});
        tag_q.push_back(tag);
        @(posedge clk);
        #1 compare_out();
    endtask

    task automatic rst(input logic clr, input string tag);
        @(negedge clk);
        reset = 1'b1; clear_fault = clr;
        exp_q.push_back('0);
        tag_q.push_back(tag);
        @(posedge clk);
        #1 compare_out();
    endtask

    task automatic short_yellow(input int n, input logic flt);
        rst(1'b0, "sy_rst");
        drive(R, Y, n);
        dc(R, R, 0, 1, 2, 1, 0, 0, 0, "sy_r_in");
        dc(R, R, 0, 1, 1, 1, flt, flt ? 3'd4 : 3'd0, flt, "sy_r_acc");
    endtask

    initial begin
        rst(1'b0, "reset");
        dc(G, R, 0, 0, 0, 0, 0, 0, 0, "acc0");
        dc(G, R, 0, 3, 1, 1, 0, 0, 0, "acc1");
        drive(G, R, 8);
        dc(Y, R, 0, 3, 1, 1, 0, 0, 0, "y_in");
        dc(Y, R, 0, 2, 1, 1, 0, 0, 0, "y_acc");
        drive(Y, R, 8);
        dc(R, R, 0, 2, 1, 1, 0, 0, 0, "r_in");
        dc(R, R, 0, 1, 1, 1, 0, 0, 0, "r_acc");
        drive(R, R, 2);

        dc(G, R, 0, 1, 1, 1, 0, 0, 0, "g_in");
        dc(G, R, 0, 3, 1, 1, 0, 0, 0, "g_acc");
        dc(X, R, 0, 3, 1, 1, 0, 0, 0, "glitch");
        dc(G, R, 0, 3, 1, 1, 0, 0, 0, "glitch_rec");
        drive(G, R, 1);
        dc(X, R, 0, 3, 1, 1, 0, 0, 0, "inv_in");
        dc(X, R, 0, 7, 1, 1, 1, 2, 0, "inv_acc");
        rst(1'b0, "rst2");

        dc(G, Y, 0, 0, 0, 0, 0, 0, 0, "cf_in");
        dc(G, Y, 0, 3, 2, 1, 1, 1, 0, "cf_acc");
        dc(G, Y, 0, 3, 2, 1, 1, 1, 0, "cf_hold");
        dc(G, Y, 1, 3, 2, 1, 0, 0, 0, "cf_clr");
        dc(G, Y, 0, 3, 2, 1, 1, 1, 0, "cf_relatch");
        dc(Y, Y, 0, 3, 2, 1, 1, 1, 0, "yy_in");
        dc(Y, Y, 0, 2, 2, 1, 1, 1, 0, "yy_acc");
        dc(Y, Y, 1, 2, 2, 1, 0, 0, 0, "yy_clr");
        drive(Y, Y, 3);
        dc(Y, Y, 0, 2, 2, 1, 0, 0, 0, "yy_quiet");

        short_yellow(5, 1'b1);
        short_yellow(7, 1'b1);
        short_yellow(8, 1'b0);

        rst(1'b0, "lg_rst");
        drive(G, R, 20);
        dc(G, R, 0, 3, 1, 1, 0, 0, 0, "lg_20");
        dc(G, R, 0, 3, 1, 1, 1, 5, 0, "lg_21");
        dc(G, R, 1, 3, 1, 1, 0, 0, 0, "lg_clr");
        drive(G, R, 3);
        dc(G, R, 0, 3, 1, 1, 0, 0, 0, "lg_norefire");

        rst(1'b0, "sq_rst");
        drive(R, G, 2);
        dc(R, R, 0, 1, 3, 1, 0, 0, 0, "sq_in");
        dc(R, R, 0, 1, 1, 1, 1, 3, 1, "sq_acc");

        rst(1'b0, "pr_rst0");
        drive(R, G, 2);
        dc(X, R, 0, 1, 3, 1, 0, 0, 0, "pr_in");
        dc(X, R, 0, 7, 1, 1, 1, 2, 0, "pr_acc");
        rst(1'b1, "pr_rst");

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/light_conflict_monitor.md
# light_conflict_monitor

Independent safety monitor that sits on the `ns_light`/`ew_light` 7-segment buses driven by the intersection controller and decodes them back into colours. It filters combinational glitches, then checks each direction against the signalling rules: no conflicting greens, legal colour order, minimum yellow dwell, maximum green dwell and legal segment codes. Any violation raises a sticky `fault`, which the top level wires to the controller's `error` input to force the flashing-error mode.

## Interface
- `SETTLE`, 4 — consecutive identical samples required before a segment code is accepted (≥1).
- `MIN_YELLOW`, 32'd100_000_000 — minimum accepted-YELLOW duration, in cycles, before RED (2 s at 50 MHz).
- `MAX_GREEN`, 32'd800_000_000 — maximum accepted-GREEN duration, in cycles (16 s).
- `clk` input 1 — system clock.
- `reset` input 1 — synchronous, active-high.
- `ns_light` input 8 — north/south segment code from the controller.
- `ew_light` input 8 — east/west segment code from the controller.
- `clear_fault` input 1 — synchronous request to clear the latched fault.
- `ns_color` output 3 — accepted NS colour.
- `ew_color` output 3 — accepted EW colour.
- `valid` output 1 — both channels have accepted at least one code since reset.
- `fault` output 1 — sticky fault flag.
- `fault_code` output 3 — cause of the first fault.
- `fault_ew` output 1 — direction of the fault: 0 = NS, 1 = EW.

## Operation
- **Decode.** 8'b10001000 = RED (1), 8'b10011001 = YELLOW (2), 8'b10000010 = GREEN (3), 8'b10000000 = ERR (4), 8'b11111111 = OFF (0). Any other code = INVALID (7).
- **Settle filter.** Each channel has its own filter.
  - Register the raw code and keep a run counter.
  - If the sampled code equals the previous sample, increment the counter (saturating); otherwise reset it.
  - The accepted class updates when a code has been sampled on SETTLE consecutive edges.
- **Dwell counter.** One 32-bit counter per channel.
  - It counts cycles the accepted class has been held and saturates at 32'hFFFF_FFFF.
  - It restarts at 1 on the edge where the accepted class changes.
- **Checks.** All checks use the accepted classes and are evaluated on every edge.
  - Code 1, CONFLICT: both channels GREEN, or one GREEN and the other YELLOW. Both YELLOW is legal (four-way flash).
  - Code 2, INVALID: a channel accepts INVALID.
  - Code 3, SEQUENCE: a channel's accepted class goes GREEN→RED directly. GREEN→YELLOW, GREEN→ERR and GREEN→OFF are legal.
  - Code 4, SHORT_YELLOW: a YELLOW→RED transition where the YELLOW dwell is < MIN_YELLOW. YELLOW→OFF, YELLOW→ERR and YELLOW→GREEN are not checked.
  - Code 5, LONG_GREEN: the GREEN dwell reaches MAX_GREEN+1.
- **Fault latch.**
  - On the first detected violation, set `fault`=1 and capture `fault_code`/`fault_ew`.
  - Later violations do not overwrite the capture while `fault`=1.
  - Simultaneous violations: the lowest code wins; for the same code, NS wins. CONFLICT reports `fault_ew`=0.
- **Clear.** `clear_fault`=1 clears `fault`, `fault_code` and `fault_ew` on that edge.
  - If a violation is detected on the same edge, it is captured instead (new fault wins over clear).
  - A persisting CONFLICT or INVALID condition re-latches on the next edge.
  - LONG_GREEN does not re-fire until the dwell restarts.
- **`valid`.** Rises on the edge where the second channel first accepts a code. It stays high until reset. No check fires while `valid`=0.

## Timing
- **Reset values.** `ns_color`=`ew_color`=0 (OFF), `valid`=0, `fault`=0, `fault_code`=0, `fault_ew`=0. Filters, run counters and dwell counters are cleared.
- **Reset mid-operation.** Reset overrides everything, including a latched fault and `clear_fault`.
- **Acceptance latency.** A code first present at edge E0 and held is reflected on `*_color` after edge E0+SETTLE−1.
- **Fault latency.** Faults caused by a transition are visible after the same edge as the colour update. There is no extra pipeline stage.
- **Glitch rejection.** A code held for fewer than SETTLE samples is never accepted and never faults.
- **Dwell for SHORT_YELLOW.** YELLOW dwell = number of edges the accepted class was YELLOW.

## Test plan
Unless stated otherwise, parameters are SETTLE=2, MIN_YELLOW=8, MAX_GREEN=20.

- **Reset and normal cycle.** Apply reset. Then drive NS GREEN 10 cycles, YELLOW 10 cycles, RED, with EW RED throughout.
  - All outputs are 0 after reset.
  - `ns_color` goes 3→2→1, each one edge after the input change.
  - `valid`=1; `fault` stays 0.
- **Glitch rejection.** During steady NS GREEN, drive `ns_light`=8'h55 for 1 cycle.
  - `ns_color` stays 3; `fault`=0.
  - The same code held 2 cycles gives `fault`=1, `fault_code`=2, `fault_ew`=0.
- **Conflict and clear.** Drive NS GREEN with EW YELLOW.
  - `fault`=1, `fault_code`=1 after acceptance.
  - Pulse `clear_fault` while the conflict persists: `fault` drops for one cycle, then re-latches with code 1.
  - Both channels YELLOW gives no fault.
- **Short yellow.** Drive EW YELLOW for 5 cycles, then RED.
  - `fault_code`=4, `fault_ew`=1.
  - With YELLOW held 8 cycles, there is no fault.
- **Long green.** Hold NS GREEN.
  - `fault` rises exactly when the accepted GREEN dwell reaches 21, with `fault_code`=5.
- **Priority, sequence and reset.** On the same edge, accept EW GREEN→RED and NS INVALID.
  - `fault_code`=2, `fault_ew`=0.
  - Assert `reset` for one cycle: all outputs return to reset values.
